// File: rtl/pc_sequencer_if.sv
// Fetch-stage program-counter bus: redirect requests in, PC and status out.
// The slave modport is the PC sequencer; the master modport is whoever drives redirects.
interface pc_sequencer_if #(
    parameter int N_BITS    = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic              stall_i;
    logic              exc_i;
    logic              ret_i;
    logic [N_BITS-1:0] ret_target_i;
    logic              jump_i;
    logic              call_i;
    logic [N_BITS-1:0] jump_target_i;
    logic              branch_taken_i;
    logic [N_BITS-1:0] branch_target_i;
    logic [N_BITS-1:0] pc_o;
    logic [N_BITS-1:0] pc_plus4_o;
    logic              flush_o;
    logic              misalign_o;
    logic [CW-1:0]     ras_count_o;

    modport master (
        output stall_i, exc_i, ret_i, ret_target_i, jump_i, call_i,
               jump_target_i, branch_taken_i, branch_target_i,
        input  pc_o, pc_plus4_o, flush_o, misalign_o, ras_count_o
    );

    modport slave (
        input  stall_i, exc_i, ret_i, ret_target_i, jump_i, call_i,
               jump_target_i, branch_taken_i, branch_target_i,
        output pc_o, pc_plus4_o, flush_o, misalign_o, ras_count_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS fetch program counter: prioritised next-PC select, flush pulse, sticky misalign flag.
// Define PC_RAS_EN to add a circular return-address stack that predicts jr $ra targets.
module pc_sequencer #(
    parameter int                N_BITS    = 32,
    parameter logic [N_BITS-1:0] RESET_VEC = N_BITS'(32'h0040_0000),
    parameter logic [N_BITS-1:0] EXC_VEC   = N_BITS'(32'h8000_0180),
    parameter int                RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [N_BITS-1:0] pc_q;
    logic [N_BITS-1:0] pc_plus4;
    logic [N_BITS-1:0] target;
    logic [N_BITS-1:0] pc_d;
    logic              load;
    logic              redirect;
    logic              flush_q;
    logic              misalign_q;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    logic [N_BITS-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]     top_ptr;
    logic [CW-1:0]     ras_count;
    logic              push;
    logic              pop;
`else
    logic unused_call;
    assign unused_call = bus.call_i;
`endif

    assign pc_plus4 = pc_q + N_BITS'(4);

    // An exception is the only source that can break through a stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        load     = bus.exc_i | ~bus.stall_i;
        redirect = 1'b0;
        target   = pc_plus4;
`ifdef PC_RAS_EN
        push     = 1'b0;
        pop      = 1'b0;
`endif
        if (bus.exc_i) begin
            redirect = 1'b1;
            target   = EXC_VEC;
        end else if (!bus.stall_i) begin
            if (bus.ret_i) begin
                redirect = 1'b1;
`ifdef PC_RAS_EN
                if (ras_count != '0) begin
                    target = ras_mem[top_ptr];
                    pop    = 1'b1;
                end else begin
                    target = bus.ret_target_i;
                end
`else
                target = bus.ret_target_i;
`endif
            end else if (bus.jump_i) begin
                redirect = 1'b1;
                target   = bus.jump_target_i;
`ifdef PC_RAS_EN
                push     = bus.call_i;
`endif
            end else if (bus.branch_taken_i) begin
                redirect = 1'b1;
                target   = bus.branch_target_i;
            end
        end
        pc_d = redirect ? {target[N_BITS-1:2], 2'b00} : pc_plus4;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc_q       <= RESET_VEC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (load) pc_q <= pc_d;
            flush_q <= load & redirect;
            if (redirect && target[1:0] != 2'b00) misalign_q <= 1'b1;
        end
    end

`ifdef PC_RAS_EN
    // Push always advances the pointer, so a push when full lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr   <= '0;
            ras_count <= '0;
        end else if (push) begin
            top_ptr <= top_ptr + PW'(1);
            if (ras_count != RAS_FULL) ras_count <= ras_count + CW'(1);
        end else if (pop) begin
            top_ptr   <= top_ptr - PW'(1);
            ras_count <= ras_count - CW'(1);
        end
    end

    // NOTE: the stack storage is not reset; ras_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) ras_mem[top_ptr + PW'(1)] <= pc_plus4;
    end

    assign bus.ras_count_o = ras_count;
`else
    assign bus.ras_count_o = {CW{1'b0}};
`endif

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_plus4;
    assign bus.flush_o    = flush_q;
    assign bus.misalign_o = misalign_q;
endmodule
